instr_issue_sequencer: RTL and testbench

//  Consumer end of the instruction queue filled by the control unit. Pops one queue entry at a time, expands it

---
 rtl/instr_issue_sequencer.sv | 173 +++++++++++++++++
 tb/tb_instr_issue_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_sequencer.sv
// instr_issue_sequencer
//   Consumer end of the control-unit instruction queue. Pops one entry at a
//   time, unrolls it into copy_count copies and issues the copies in order,
//   one per cycle, to the load/store, RAM (DMA) or arithmetic unit over
//   valid/ready. Copy k carries cache/main addresses base + k*delta.
//   A PROG_END entry produces a one-cycle prog_done pulse.
//
// Ports
//   clk, reset_n                  clock / async active-low reset
//   queue_*                       show-ahead FIFO head + combinational pop
//   ld_st_{valid,ready,instr,cache_addr}
//   ram_{valid,ready,instr,cache_addr,main_mem_addr}
//   arith_{valid,ready,instr}     per-unit issue channels
//   issue_copy_idx                copy index k currently presented
//   prog_done                     one-cycle pulse when PROG_END is consumed
//   busy                          state != IDLE
//   seq_error                     sticky: illegal copy_count popped
module instr_issue_sequencer #(
  parameter int LOG_SUPERSCALAR_WIDTH = 3,
  parameter int ADDR_W                = 18
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             queue_empty,
  output logic                             queue_pop,
  input  logic [1:0]                       queue_instr_type,
  input  logic [LOG_SUPERSCALAR_WIDTH:0]   queue_copy_count,
  input  logic [ADDR_W-1:0]                queue_cache_addr,
  input  logic [ADDR_W-1:0]                queue_main_mem_addr,
  input  logic [ADDR_W-1:0]                queue_d_cache_addr,
  input  logic [ADDR_W-1:0]                queue_d_main_mem_addr,
  input  logic [8:0]                       queue_arith_instr,
  input  logic [2:0]                       queue_ram_instr,
  input  logic [6:0]                       queue_ld_st_instr,
  output logic                             ld_st_valid,
  input  logic                             ld_st_ready,
  output logic [6:0]                       ld_st_instr,
  output logic [ADDR_W-1:0]                ld_st_cache_addr,
  output logic                             ram_valid,
  input  logic                             ram_ready,
  output logic [2:0]                       ram_instr,
  output logic [ADDR_W-1:0]                ram_cache_addr,
  output logic [ADDR_W-1:0]                ram_main_mem_addr,
  output logic                             arith_valid,
  input  logic                             arith_ready,
  output logic [8:0]                       arith_instr,
  output logic [LOG_SUPERSCALAR_WIDTH-1:0] issue_copy_idx,
  output logic                             prog_done,
  output logic                             busy,
  output logic                             seq_error
);

  localparam int LSW = LOG_SUPERSCALAR_WIDTH;
  localparam int CW  = LSW + 1;
  localparam logic [CW-1:0] MAX_COPIES = CW'(1 << LSW);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
  typedef enum logic [1:0] {T_LDST = 2'd0, T_RAM = 2'd1, T_ARITH = 2'd2, T_END = 2'd3} itype_t;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_k;
  logic [ADDR_W-1:0]   r_cache_addr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   r_d_cache;
  logic [ADDR_W-1:0]   r_d_mem;
  logic [6:0]          r_ld_st_instr;
  logic [2:0]          r_ram_instr;
  logic [8:0]          r_arith_instr;
  logic                r_ld_st_valid;
  logic                r_ram_valid;
  logic                r_arith_valid;
  logic                r_prog_done;
  logic                r_seq_error;

  logic                w_fire;
  logic                w_count_ok;
  logic [CW-1:0]       w_k_next;

  // Pop is suppressed while reset is held so no entry is lost during reset.
  assign queue_pop  = reset_n && (r_state == S_IDLE) && !queue_empty;
  assign w_count_ok = (queue_copy_count != '0) && (queue_copy_count <= MAX_COPIES);
  assign w_k_next   = r_k + CW'(1);

  // Only the selected unit's ready matters; the other valids are low.
  assign w_fire = (r_ld_st_valid && ld_st_ready) ||
                  (r_ram_valid   && ram_ready)   ||
                  (r_arith_valid && arith_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_k           <= '0;
      r_cache_addr  <= '0;
      r_mem_addr    <= '0;
      r_d_cache     <= '0;
      r_d_mem       <= '0;
      r_ld_st_instr <= '0;
      r_ram_instr   <= '0;
      r_arith_instr <= '0;
      r_ld_st_valid <= 1'b0;
      r_ram_valid   <= 1'b0;
      r_arith_valid <= 1'b0;
      r_prog_done   <= 1'b0;
      r_seq_error   <= 1'b0;
    end else begin
      r_prog_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (queue_pop) begin
            if (itype_t'(queue_instr_type) == T_END) begin
              r_state     <= S_DONE;
              r_prog_done <= 1'b1;
            end else if (!w_count_ok) begin
              // Bad entry is dropped; flag stays until reset.
              r_seq_error <= 1'b1;
            end else begin
              r_state       <= S_ISSUE;
              r_count       <= queue_copy_count;
              r_k           <= '0;
              r_cache_addr  <= queue_cache_addr;
              r_mem_addr    <= queue_main_mem_addr;
              r_d_cache     <= queue_d_cache_addr;
              r_d_mem       <= queue_d_main_mem_addr;
              r_ld_st_instr <= queue_ld_st_instr;
              r_ram_instr   <= queue_ram_instr;
              r_arith_instr <= queue_arith_instr;
              r_ld_st_valid <= (itype_t'(queue_instr_type) == T_LDST);
              r_ram_valid   <= (itype_t'(queue_instr_type) == T_RAM);
              r_arith_valid <= (itype_t'(queue_instr_type) == T_ARITH);
            end
          end
        end
        S_ISSUE: begin
          if (w_fire) begin
            // Running sum gives base + k*delta with natural ADDR_W wrap.
            r_k          <= w_k_next;
            r_cache_addr <= r_cache_addr + r_d_cache;
            r_mem_addr   <= r_mem_addr + r_d_mem;
            if (w_k_next == r_count) begin
              r_state       <= S_IDLE;
              r_ld_st_valid <= 1'b0;
              r_ram_valid   <= 1'b0;
              r_arith_valid <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ld_st_valid       = r_ld_st_valid;
  assign ld_st_instr       = r_ld_st_instr;
  assign ld_st_cache_addr  = r_cache_addr;
  assign ram_valid         = r_ram_valid;
  assign ram_instr         = r_ram_instr;
  assign ram_cache_addr    = r_cache_addr;
  assign ram_main_mem_addr = r_mem_addr;
  assign arith_valid       = r_arith_valid;
  assign arith_instr       = r_arith_instr;
  assign issue_copy_idx    = r_k[LSW-1:0];
  assign prog_done         = r_prog_done;
  assign busy              = (r_state != S_IDLE);
  assign seq_error         = r_seq_error;

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Bench for instr_issue_sequencer: a FIFO model feeds the head, expected
// copies are queued on push and checked as each copy is accepted.
module tb_instr_issue_sequencer;

  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          queue_empty;
  logic          queue_pop;
  logic [1:0]    queue_instr_type;
  logic [3:0]    queue_copy_count;
  logic [AW-1:0] queue_cache_addr, queue_main_mem_addr, queue_d_cache_addr, queue_d_main_mem_addr;
  logic [8:0]    queue_arith_instr;
  logic [2:0]    queue_ram_instr;
  logic [6:0]    queue_ld_st_instr;
  logic          ld_st_valid, ld_st_ready;
  logic [6:0]    ld_st_instr;
  logic [AW-1:0] ld_st_cache_addr;
  logic          ram_valid, ram_ready;
  logic [2:0]    ram_instr;
  logic [AW-1:0] ram_cache_addr, ram_main_mem_addr;
  logic          arith_valid, arith_ready;
  logic [8:0]    arith_instr;
  logic [2:0]    issue_copy_idx;
  logic          prog_done, busy, seq_error;

  instr_issue_sequencer #(.LOG_SUPERSCALAR_WIDTH(3), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .queue_empty(queue_empty), .queue_pop(queue_pop),
    .queue_instr_type(queue_instr_type), .queue_copy_count(queue_copy_count),
    .queue_cache_addr(queue_cache_addr), .queue_main_mem_addr(queue_main_mem_addr),
    .queue_d_cache_addr(queue_d_cache_addr), .queue_d_main_mem_addr(queue_d_main_mem_addr),
    .queue_arith_instr(queue_arith_instr), .queue_ram_instr(queue_ram_instr),
    .queue_ld_st_instr(queue_ld_st_instr),
    .ld_st_valid(ld_st_valid), .ld_st_ready(ld_st_ready), .ld_st_instr(ld_st_instr),
    .ld_st_cache_addr(ld_st_cache_addr),
    .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_instr(ram_instr),
    .ram_cache_addr(ram_cache_addr), .ram_main_mem_addr(ram_main_mem_addr),
    .arith_valid(arith_valid), .arith_ready(arith_ready), .arith_instr(arith_instr),
    .issue_copy_idx(issue_copy_idx), .prog_done(prog_done), .busy(busy), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    ty;
    logic [3:0]    cnt;
    logic [AW-1:0] ca, ma, dca, dma;
    logic [8:0]    ar;
    logic [2:0]    ra;
    logic [6:0]    ls;
  } ent_t;

  ent_t        fifo[$];
  logic [63:0] exp_q[$];
  int total = 0, bad = 0, pops = 0, issues = 0, pd_cyc = 0;
  logic pop_seen = 1'b0, rand_rdy = 1'b0, hold = 1'b0;
  logic [63:0] held = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] pk(logic [1:0] u, logic [8:0] ins, logic [AW-1:0] ca,
                                     logic [AW-1:0] ma, logic [2:0] k);
    return {14'd0, u, ins, ca, ma, k};
  endfunction

  function automatic ent_t mk(logic [1:0] ty, logic [3:0] cnt, logic [AW-1:0] ca, logic [AW-1:0] dca,
                              logic [AW-1:0] ma, logic [AW-1:0] dma, logic [8:0] ar,
                              logic [2:0] ra, logic [6:0] ls);
    ent_t e;
    e.ty = ty; e.cnt = cnt; e.ca = ca; e.dca = dca; e.ma = ma; e.dma = dma;
    e.ar = ar; e.ra = ra; e.ls = ls;
    return e;
  endfunction

  // Queue the entry and the copies it must produce (base + k*delta, truncated).
  task automatic push_ent(input ent_t e);
    logic [AW-1:0] ca, ma;
    fifo.push_back(e);
    if (e.ty != 2'd3 && e.cnt >= 4'd1 && e.cnt <= 4'd8) begin
      for (int k = 0; k < int'(e.cnt); k++) begin
        ca = e.ca + AW'(k) * e.dca;
        ma = e.ma + AW'(k) * e.dma;
        case (e.ty)
          2'd0:    exp_q.push_back(pk(2'd0, {2'b0, e.ls}, ca, '0, 3'(k)));
          2'd1:    exp_q.push_back(pk(2'd1, {6'b0, e.ra}, ca, ma, 3'(k)));
          default: exp_q.push_back(pk(2'd2, e.ar, '0, '0, 3'(k)));
        endcase
      end
    end
  endtask

  // FIFO head driver + scoreboard monitor. Inputs change at negedge,
  // outputs sampled 1 time unit later.
  always @(negedge clk) begin
    logic [63:0] cur;
    logic        anyv, sel_rdy;
    if (pop_seen && fifo.size() > 0) begin
      fifo.delete(0);
      pops++;
    end
    if (fifo.size() > 0) begin
      queue_empty           = 1'b0;
      queue_instr_type      = fifo[0].ty;
      queue_copy_count      = fifo[0].cnt;
      queue_cache_addr      = fifo[0].ca;
      queue_main_mem_addr   = fifo[0].ma;
      queue_d_cache_addr    = fifo[0].dca;
      queue_d_main_mem_addr = fifo[0].dma;
      queue_arith_instr     = fifo[0].ar;
      queue_ram_instr       = fifo[0].ra;
      queue_ld_st_instr     = fifo[0].ls;
    end else begin
      queue_empty           = 1'b1;
      queue_instr_type      = 2'($urandom);
      queue_copy_count      = 4'($urandom);
      queue_cache_addr      = AW'($urandom);
      queue_main_mem_addr   = AW'($urandom);
      queue_d_cache_addr    = AW'($urandom);
      queue_d_main_mem_addr = AW'($urandom);
      queue_arith_instr     = 9'($urandom);
      queue_ram_instr       = 3'($urandom);
      queue_ld_st_instr     = 7'($urandom);
    end
    if (rand_rdy) begin
      ld_st_ready = 1'($urandom_range(0, 1));
      ram_ready   = 1'($urandom_range(0, 1));
      arith_ready = 1'($urandom_range(0, 1));
    end
    #1;
    pop_seen = queue_pop;
    if (prog_done) pd_cyc++;
    anyv = ld_st_valid | ram_valid | arith_valid;
    cur = '0; sel_rdy = 1'b0;
    if (ld_st_valid) begin
      cur = pk(2'd0, {2'b0, ld_st_instr}, ld_st_cache_addr, '0, issue_copy_idx); sel_rdy = ld_st_ready;
    end else if (ram_valid) begin
      cur = pk(2'd1, {6'b0, ram_instr}, ram_cache_addr, ram_main_mem_addr, issue_copy_idx); sel_rdy = ram_ready;
    end else if (arith_valid) begin
      cur = pk(2'd2, arith_instr, '0, '0, issue_copy_idx); sel_rdy = arith_ready;
    end
    if (anyv || prog_done)
      chk("onehot", 128'($countones({ld_st_valid, ram_valid, arith_valid, prog_done})), 128'd1);
    if (hold && anyv) chk("stable", cur, held);
    hold = anyv && !sel_rdy;
    held = cur;
    if (anyv && sel_rdy) begin
      issues++;
      if (exp_q.size() == 0) chk("spurious_issue", 128'(exp_q.size()), 128'd1);
      else chk("issue", cur, exp_q.pop_front());
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while ((fifo.size() != 0 || exp_q.size() != 0 || busy) && n < maxc);
    chk("drain", {32'(fifo.size()), 32'(exp_q.size()), 31'd0, busy}, '0);
  endtask

  task automatic all_out_zero(input string tag);
    chk(tag, {ld_st_valid, ram_valid, arith_valid, prog_done, busy, seq_error, issue_copy_idx,
              ld_st_instr, ram_instr, arith_instr}, '0);
    chk({tag, "_addr"}, {ld_st_cache_addr, ram_cache_addr, ram_main_mem_addr}, '0);
  endtask

  initial begin
    int p0, found;
    ent_t e;
    reset_n = 1'b0;
    ld_st_ready = 1'b1; ram_ready = 1'b1; arith_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    all_out_zero("reset");
    chk("reset_pop", 128'(queue_pop), 128'd0);
    @(negedge clk); #3 reset_n = 1'b1;

    // 1: ld/st x3, base 100 delta 4
    p0 = pops;
    @(negedge clk);
    push_ent(mk(2'd0, 4'd3, 18'd100, 18'd4, 18'd0, 18'd0, 9'd0, 3'd0, 7'h5A));
    drain(40);
    chk("t1_pops", 128'(pops - p0), 128'd1);

    // 2: RAM x2 with main address wrap, ready held low for 3 valid cycles
    @(negedge clk);
    ram_ready = 1'b0;
    push_ent(mk(2'd1, 4'd2, 18'd10, 18'd1, 18'h3FFFE, 18'd2, 9'd0, 3'b110, 7'd0));
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (ram_valid) found = 1;
    end
    chk("t2_valid_seen", 128'(found), 128'd1);
    repeat (3) @(negedge clk);
    ram_ready = 1'b1;
    drain(40);

    // 3: arith x8 then PROG_END back-to-back; foreign readies toggled
    pd_cyc = 0;
    @(negedge clk);
    ld_st_ready = 1'b0; ram_ready = 1'b1;
    push_ent(mk(2'd2, 4'd8, 18'd0, 18'd0, 18'd0, 18'd0, 9'h1C3, 3'd0, 7'd0));
    push_ent(mk(2'd3, 4'd0, 18'd0, 18'd0, 18'd0, 18'd0, 9'd0, 3'd0, 7'd0));
    drain(60);
    chk("t3_prog_done_cycles", 128'(pd_cyc), 128'd1);
    chk("t3_busy_after", 128'(busy), 128'd0);
    chk("t3_no_err", 128'(seq_error), 128'd0);
    ld_st_ready = 1'b1;

    // 4: count=0 and count=9 dropped, then a normal ld/st x1
    @(negedge clk);
    push_ent(mk(2'd0, 4'd0, 18'd7, 18'd1, 18'd0, 18'd0, 9'd0, 3'd0, 7'h11));
    push_ent(mk(2'd1, 4'd9, 18'd7, 18'd1, 18'd0, 18'd0, 9'd0, 3'd1, 7'h00));
    push_ent(mk(2'd0, 4'd1, 18'd300, 18'd5, 18'd0, 18'd0, 9'd0, 3'd0, 7'h22));
    drain(40);
    chk("t4_seq_error", 128'(seq_error), 128'd1);

    // random mix with random readies, ending in PROG_END
    rand_rdy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = mk(2'($urandom_range(0, 2)), 4'($urandom_range(1, 8)), AW'($urandom), AW'($urandom),
             AW'($urandom), AW'($urandom), 9'($urandom), 3'($urandom), 7'($urandom));
      push_ent(e);
    end
    push_ent(mk(2'd3, 4'd1, 18'd0, 18'd0, 18'd0, 18'd0, 9'd0, 3'd0, 7'd0));
    drain(600);
    rand_rdy = 1'b0;
    @(negedge clk);
    ld_st_ready = 1'b1; ram_ready = 1'b1; arith_ready = 1'b1;
    chk("mix_err_sticky", 128'(seq_error), 128'd1);

    // 5: reset mid-ISSUE at k=2 of 5, with another entry waiting
    push_ent(mk(2'd0, 4'd5, 18'd200, 18'd3, 18'd0, 18'd0, 9'd0, 3'd0, 7'h33));
    push_ent(mk(2'd0, 4'd2, 18'd400, 18'd1, 18'd0, 18'd0, 9'd0, 3'd0, 7'h44));
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (ld_st_valid && issue_copy_idx == 3'd2) found = 1;
    end
    chk("t5_reach_k2", 128'(found), 128'd1);
    #3 reset_n = 1'b0;
    #1;
    all_out_zero("t5_reset");
    chk("t5_pop_in_reset", 128'(queue_pop), 128'd0);
    repeat (2) begin
      @(negedge clk); #2;
      chk("t5_pop_held", {queue_empty, queue_pop}, 128'd0);
    end
    fifo.delete();
    exp_q.delete();
    @(negedge clk); #3 reset_n = 1'b1;

    // 6: empty queue with garbage head fields
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      chk("t6_idle", {queue_pop, busy, ld_st_valid, ram_valid, arith_valid}, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
